// File: rtl/icache_dm_ctrl.sv
// Direct-mapped, read-only instruction cache controller between the fetch stage
// and the instruction-memory bus. Misses refill a whole line, beats in ascending order.

module equal_20bit (
  input  logic [19:0] a,
  input  logic [19:0] b,
  output logic        eq
);
  assign eq = (a == b);
endmodule

module icache_dm_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  input  logic        i_flush,
  output logic        o_mem_req_valid,
  output logic [31:0] o_mem_req_addr,
  input  logic        i_mem_req_ready,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic        o_hit,
  output logic [2:0]  o_dbg_state
);

  // Handshakes: a request transfers on a cycle with i_req_valid & o_req_ready, a refill
  // request on o_mem_req_valid & i_mem_req_ready; o_mem_req_valid/addr hold until then.
  // Responses and refill beats are valid-only: no backpressure on either.

  localparam int WORD_W   = $clog2(LINE_WORDS);
  localparam int OFFSET_W = WORD_W + 2;
  localparam int LINES    = 1 << INDEX_W;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;  // only legal at 20
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MISS_REQ = 3'd2,
    S_REFILL   = 3'd3,
    S_RESPOND  = 3'd4
  } state_t;

  state_t              state;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   beat_q;
  logic [LINES-1:0]    valid_q;
  logic                flush_pending;
  logic [31:0]         rsp_data_q;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [LINES][LINE_WORDS];
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_word;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [WORD_W-1:0]   req_word;
  logic                unused_addr_bits;
  logic                accept;
  logic                tag_match;
  logic                lookup_hit;

  assign req_tag          = i_req_addr[31 -: TAG_W];
  assign req_idx          = i_req_addr[OFFSET_W +: INDEX_W];
  assign req_word         = i_req_addr[2 +: WORD_W];
  assign unused_addr_bits = ^i_req_addr[1:0];

  assign o_req_ready = (state == S_IDLE) & ~flush_pending & ~i_flush & ~i_reset;
  assign accept      = o_req_ready & i_req_valid;

  equal_20bit u_tag_eq (
    .a  (rd_tag),
    .b  (tag_q),
    .eq (tag_match)
  );

  assign lookup_hit = valid_q[idx_q] & tag_match;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      valid_q       <= '0;
      flush_pending <= 1'b0;
      beat_q        <= '0;
      rsp_data_q    <= '0;
      tag_q         <= '0;
      idx_q         <= '0;
      word_q        <= '0;
    end else begin
      // A flush outside IDLE is deferred so an in-flight refill still completes.
      if (i_flush && state != S_IDLE) flush_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (flush_pending || i_flush) begin
            valid_q       <= '0;
            flush_pending <= 1'b0;
          end else if (i_req_valid) begin
            tag_q  <= req_tag;
            idx_q  <= req_idx;
            word_q <= req_word;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: state <= lookup_hit ? S_IDLE : S_MISS_REQ;
        S_MISS_REQ: begin
          if (i_mem_req_ready) begin
            beat_q <= '0;
            state  <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (i_mem_rsp_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == word_q) rsp_data_q <= i_mem_rsp_data;
            if (beat_q == LAST_BEAT) begin
              valid_q[idx_q] <= 1'b1;
              state          <= S_RESPOND;
            end
          end
        end
        S_RESPOND: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Tag/data arrays: synchronous read at acceptance, write per refill beat; never reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      rd_tag  <= tag_mem[req_idx];
      rd_word <= data_mem[req_idx][req_word];
    end
    if (!i_reset && state == S_REFILL && i_mem_rsp_valid) begin
      data_mem[idx_q][beat_q] <= i_mem_rsp_data;
      if (beat_q == LAST_BEAT) tag_mem[idx_q] <= tag_q;
    end
  end

  assign o_hit           = ~i_reset & (state == S_LOOKUP) & lookup_hit;
  assign o_rsp_valid     = o_hit | (~i_reset & (state == S_RESPOND));
  assign o_rsp_data      = o_hit ? rd_word :
                           ((state == S_RESPOND) ? rsp_data_q : 32'h0);
  assign o_mem_req_valid = ~i_reset & (state == S_MISS_REQ);
  assign o_mem_req_addr  = (state == S_MISS_REQ) ? {tag_q, idx_q, {OFFSET_W{1'b0}}} : 32'h0;
  assign o_dbg_state     = state;

endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Bench for icache_dm_ctrl: memory responder, cache reference model kept as
// plain valid/tag arrays, and per-scenario tasks with inline comparisons.

module tb_icache_dm_ctrl;

  localparam int LW = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        i_flush = 1'b0;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_req_ready = 1'b0;
  logic        i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rsp_data = 32'h0;
  logic        o_hit;
  logic [2:0]  o_dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_pre [logic [31:0]];
  bit          ref_valid [256];
  logic [19:0] ref_tag [256];
  logic [31:0] exp_q [$];

  always #5 i_clk = ~i_clk;

  icache_dm_ctrl dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_req_valid     (i_req_valid),
    .i_req_addr      (i_req_addr),
    .o_req_ready     (o_req_ready),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_data      (o_rsp_data),
    .i_flush         (i_flush),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_req_addr  (o_mem_req_addr),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_data  (i_mem_rsp_data),
    .o_hit           (o_hit),
    .o_dbg_state     (o_dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem_pre.exists(wa)) return mem_pre[wa];
    return {wa[15:0], ~wa[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return ref_valid[a[11:4]] && (ref_tag[a[11:4]] == a[31:12]);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    ref_valid[a[11:4]] = 1'b1;
    ref_tag[a[11:4]]   = a[31:12];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
  endfunction

  // Issues one request and plays the memory side until a response arrives
  // (or ten cycles after a mid-refill reset). Called and returns at posedge+1.
  task automatic fetch(input logic [31:0] addr, input int req_wait, input int gap,
                       input int flush_at, input int reset_at, input bit flush_with_req,
                       output bit accepted, output bit rsp_seen, output logic [31:0] rsp_data,
                       output bit hit_at_rsp, output bit hit_any, output int lat,
                       output int req_cycles, output bit addr_bad, output int beats);
    logic [31:0] line;
    int wait_cnt, gap_cnt, post_reset;
    bit sending, did_reset;
    line = {addr[31:4], 4'h0};
    accepted = 0; rsp_seen = 0; rsp_data = 32'h0; hit_at_rsp = 0; hit_any = 0;
    lat = 0; req_cycles = 0; addr_bad = 0; beats = 0;
    wait_cnt = 0; gap_cnt = 0; post_reset = 0; sending = 0; did_reset = 0;
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    for (int k = 0; k < 20 && !accepted; k++) begin
      i_flush = (k == 0) && flush_with_req;
      #3;
      if (o_req_ready === 1'b1) accepted = 1;
      @(posedge i_clk); #1;
    end
    i_req_valid = 1'b0;
    i_flush = 1'b0;
    if (!accepted) return;
    for (int c = 1; c <= 400; c++) begin
      i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 32'h0;
      i_flush = 1'b0; i_reset = 1'b0;
      if (did_reset) begin
        post_reset++;
        if (post_reset <= 2) begin
          i_mem_rsp_valid = 1'b1;
          i_mem_rsp_data  = 32'hDEAD_BEEF;
        end
      end else if (o_mem_req_valid === 1'b1 && !sending) begin
        i_mem_req_ready = (wait_cnt >= req_wait);
      end else if (sending && beats < LW) begin
        if (reset_at >= 0 && beats == reset_at) begin
          i_reset = 1'b1; did_reset = 1; sending = 0;
        end else if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          i_mem_rsp_valid = 1'b1;
          i_mem_rsp_data  = mem_word(line + 32'(beats * 4));
          if (beats == flush_at) i_flush = 1'b1;
          beats++;
          gap_cnt = gap;
        end
      end
      #3;
      if (o_hit === 1'b1) hit_any = 1;
      if (o_mem_req_valid === 1'b1) begin
        req_cycles++;
        if (o_mem_req_addr !== line) addr_bad = 1;
        wait_cnt++;
        if (i_mem_req_ready) sending = 1;
      end
      if (o_rsp_valid === 1'b1 && !rsp_seen) begin
        rsp_seen = 1; rsp_data = o_rsp_data; hit_at_rsp = o_hit; lat = c;
      end
      @(posedge i_clk); #1;
      if (rsp_seen) break;
      if (did_reset && post_reset >= 10) break;
    end
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = 32'h0;
    i_flush = 1'b0; i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    #3;
    tests_run++;
    if ({o_req_ready, o_rsp_valid, o_mem_req_valid, o_hit} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got ready/rsp/memreq/hit=%b exp 0000",
               {o_req_ready, o_rsp_valid, o_mem_req_valid, o_hit});
    end
    tests_run++;
    if ({o_rsp_data, o_mem_req_addr} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got rsp_data=%h mem_addr=%h exp 0", o_rsp_data, o_mem_req_addr);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    #3;
    tests_run++;
    if (o_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b exp 1", o_req_ready);
    end
    @(posedge i_clk); #1;
    model_clear();
  endtask

  task automatic test_cold_miss_and_hit();
    bit acc, seen, hr, ha, bad; logic [31:0] d; int lat, rc, bt;
    fetch(32'h0000_1008, 0, 0, -1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (!acc || !seen || d !== 32'hA2) begin
      tests_failed++;
      $display("FAIL cold_data: got acc=%0d seen=%0d data=%h exp 1 1 000000a2", acc, seen, d);
    end
    tests_run++;
    if (lat != 7 || rc != 1 || bad || ha) begin
      tests_failed++;
      $display("FAIL cold_timing: got lat=%0d reqcyc=%0d addr_bad=%0d hit=%0d exp 7 1 0 0", lat, rc, bad, ha);
    end
    model_fill(32'h0000_1008);
    fetch(32'h0000_100C, 0, 0, -1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (!seen || d !== 32'hA3 || lat != 1 || !hr || rc != 0) begin
      tests_failed++;
      $display("FAIL hit: got seen=%0d data=%h lat=%0d hit=%0d reqcyc=%0d exp 1 000000a3 1 1 0",
               seen, d, lat, hr, rc);
    end
  endtask

  task automatic test_conflict();
    bit acc, seen, hr, ha, bad; logic [31:0] d; int lat, rc, bt;
    fetch(32'h0000_2008, 0, 0, -1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (!seen || d !== mem_word(32'h0000_2008) || lat != 7 || rc != 1 || bad) begin
      tests_failed++;
      $display("FAIL conflict_miss: got data=%h lat=%0d reqcyc=%0d exp %h 7 1",
               d, lat, rc, mem_word(32'h0000_2008));
    end
    model_fill(32'h0000_2008);
    fetch(32'h0000_1008, 0, 0, -1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (!seen || d !== 32'hA2 || lat != 7 || rc != 1 || ha) begin
      tests_failed++;
      $display("FAIL conflict_remiss: got data=%h lat=%0d reqcyc=%0d hit=%0d exp 000000a2 7 1 0",
               d, lat, rc, ha);
    end
    model_fill(32'h0000_1008);
  endtask

  task automatic test_backpressure_gaps();
    bit acc, seen, hr, ha, bad; logic [31:0] d; int lat, rc, bt;
    fetch(32'h0000_3014, 5, 2, -1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (rc != 6 || bad) begin
      tests_failed++;
      $display("FAIL bp_request: got reqcyc=%0d addr_bad=%0d exp 6 0", rc, bad);
    end
    tests_run++;
    if (!seen || d !== mem_word(32'h0000_3014) || bt != 4 || lat != 18) begin
      tests_failed++;
      $display("FAIL bp_response: got data=%h beats=%0d lat=%0d exp %h 4 18",
               d, bt, lat, mem_word(32'h0000_3014));
    end
    model_fill(32'h0000_3014);
  endtask

  task automatic test_flush();
    bit acc, seen, hr, ha, bad; logic [31:0] d; int lat, rc, bt;
    fetch(32'h0000_4018, 0, 0, 1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (!seen || d !== mem_word(32'h0000_4018) || lat != 7) begin
      tests_failed++;
      $display("FAIL flush_rsp: got seen=%0d data=%h lat=%0d exp 1 %h 7",
               seen, d, lat, mem_word(32'h0000_4018));
    end
    #3;
    tests_run++;
    if (o_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: got %b exp 0", o_req_ready);
    end
    @(posedge i_clk); #1;
    model_clear();
    fetch(32'h0000_4018, 0, 0, -1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (!seen || ha || rc != 1 || d !== mem_word(32'h0000_4018)) begin
      tests_failed++;
      $display("FAIL flush_remiss: got hit=%0d reqcyc=%0d data=%h exp 0 1 %h",
               ha, rc, d, mem_word(32'h0000_4018));
    end
    model_fill(32'h0000_4018);
    // Flush presented together with a request wins; the request then misses.
    fetch(32'h0000_4018, 0, 0, -1, -1, 1, acc, seen, d, hr, ha, lat, rc, bad, bt);
    model_clear();
    tests_run++;
    if (!seen || ha || rc != 1) begin
      tests_failed++;
      $display("FAIL flush_priority: got seen=%0d hit=%0d reqcyc=%0d exp 1 0 1", seen, ha, rc);
    end
    model_fill(32'h0000_4018);
  endtask

  task automatic test_reset_mid_refill();
    bit acc, seen, hr, ha, bad; logic [31:0] d; int lat, rc, bt;
    fetch(32'h0000_5024, 0, 0, -1, 2, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    model_clear();
    tests_run++;
    if (seen || bt != 2) begin
      tests_failed++;
      $display("FAIL rst_refill_rsp: got rsp_seen=%0d beats=%0d exp 0 2", seen, bt);
    end
    #3;
    tests_run++;
    if (o_req_ready !== 1'b1 || o_mem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_refill_idle: got ready=%b memreq=%b exp 1 0", o_req_ready, o_mem_req_valid);
    end
    @(posedge i_clk); #1;
    fetch(32'h0000_5024, 0, 0, -1, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
    tests_run++;
    if (!seen || ha || rc != 1 || d !== mem_word(32'h0000_5024)) begin
      tests_failed++;
      $display("FAIL rst_refill_remiss: got hit=%0d reqcyc=%0d data=%h exp 0 1 %h",
               ha, rc, d, mem_word(32'h0000_5024));
    end
    model_fill(32'h0000_5024);
  endtask

  task automatic test_random();
    bit acc, seen, hr, ha, bad, exp_hit; logic [31:0] d, a, e; int lat, rc, bt, rw, g, fa;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_flush = 1'b1;
        #3;
        tests_run++;
        if (o_req_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL rnd_idle_flush_ready: got %b exp 0", o_req_ready);
        end
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        model_clear();
      end
      a  = {20'($urandom_range(1, 3)), 8'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rw = $urandom_range(0, 2);
      g  = $urandom_range(0, 1);
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      exp_hit = model_hit(a);
      exp_q.push_back(mem_word({a[31:2], 2'b00}));
      fetch(a, rw, g, fa, -1, 0, acc, seen, d, hr, ha, lat, rc, bad, bt);
      e = exp_q.pop_front();
      tests_run++;
      if (!seen || d !== e) begin
        tests_failed++;
        $display("FAIL rnd_data[%0d]: addr=%h got seen=%0d data=%h exp %h", n, a, seen, d, e);
      end
      tests_run++;
      if (exp_hit ? (lat != 1 || !hr || rc != 0)
                  : (lat != 7 + rw + 3 * g || ha || rc != rw + 1 || bad)) begin
        tests_failed++;
        $display("FAIL rnd_timing[%0d]: addr=%h got lat=%0d hit=%0d reqcyc=%0d exp hit=%0d lat=%0d",
                 n, a, lat, ha, rc, exp_hit, exp_hit ? 1 : 7 + rw + 3 * g);
      end
      if (!exp_hit) begin
        model_fill(a);
        if (fa >= 0) begin
          model_clear();
          @(posedge i_clk); #1;
        end
      end
    end
  endtask

  initial begin
    mem_pre[32'h0000_1000] = 32'hA0;
    mem_pre[32'h0000_1004] = 32'hA1;
    mem_pre[32'h0000_1008] = 32'hA2;
    mem_pre[32'h0000_100C] = 32'hA3;
    model_clear();
    @(posedge i_clk); #1;
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_backpressure_gaps();
    test_flush();
    test_reset_mid_refill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icache_dm_ctrl.md
Name: icache_dm_ctrl

Overview:
- Direct-mapped, read-only instruction cache controller between the fetch stage and the instruction-memory bus.
- Splits the 32-bit fetch address into tag, index and offset, reads the tag/valid/data arrays, and decides hit/miss with one equal_20bit instance on the stored versus requested 20-bit tag.
- On a miss it refills one whole line from memory over a valid/ready handshake, then returns the requested word.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2); OFFSET_W = log2(LINE_WORDS)+2.
- INDEX_W, 8, index bits; lines = 2^INDEX_W. Legal only when INDEX_W+OFFSET_W == 12, so tag = addr[31:12] (20 bits).

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  fetch request valid
- i_req_addr  in  32  fetch byte address; bits [1:0] ignored
- o_req_ready  out  1  request accepted when valid&ready
- o_rsp_valid  out  1  one-cycle pulse; o_rsp_data valid
- o_rsp_data  out  32  fetched instruction word
- i_flush  in  1  invalidate all lines (one-cycle pulse allowed)
- o_mem_req_valid  out  1  line refill request
- o_mem_req_addr  out  32  line-aligned address {tag,index,OFFSET_W'b0}
- i_mem_req_ready  in  1  memory accepts request
- i_mem_rsp_valid  in  1  refill beat valid; beats arrive in ascending word order
- i_mem_rsp_data  in  32  refill beat data
- o_hit  out  1  pulse in LOOKUP when lookup hits (perf counter hook)

Behaviour:
- The clock and reset are i_clk and i_reset; the reset is synchronous and active-high.
- Reset values: state=IDLE, all valid bits 0, flush_pending 0, beat counter 0, o_req_ready 0 in the reset cycle, all other outputs 0. Tag/data arrays are not reset.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
- IDLE:
  - If flush_pending or i_flush: clear all valid bits this cycle, clear flush_pending, o_req_ready=0, stay in IDLE.
  - Otherwise o_req_ready=1. On i_req_valid, register the address, issue a synchronous read of the tag/valid/data arrays at the index, and go to LOOKUP.
- LOOKUP:
  - hit = valid[index] & equal_20bit(stored_tag, req_tag).
  - On hit: o_rsp_valid=1, o_rsp_data = data[index][word offset], o_hit=1, go to IDLE. Hit latency is 1 cycle after acceptance; throughput is 1 request per 2 cycles.
  - On miss: go to MISS_REQ.
- MISS_REQ: drive o_mem_req_valid=1 with a stable o_mem_req_addr until i_mem_req_ready; in that handshake cycle go to REFILL with beat counter=0.
- REFILL:
  - Each i_mem_rsp_valid writes the beat into data[index][beat] and increments the counter.
  - The beat whose number equals the requested word offset is captured into the response register.
  - On the last beat (counter = LINE_WORDS-1): write the tag, set valid[index]=1, go to RESPOND.
  - Gaps between beats (i_mem_rsp_valid=0) are legal; the counter holds.
- RESPOND: o_rsp_valid=1 with the captured word, go to IDLE. Miss latency = 3 + memory request wait + beat cycles.
- The response side has no backpressure; the fetch stage always accepts o_rsp_valid.
- Flush:
  - i_flush in any non-IDLE state sets flush_pending.
  - The in-flight refill completes and still responds; the line is invalidated at the next IDLE cycle before any new request is accepted.
  - Flush in IDLE takes priority over a simultaneous request.
- Only one miss is outstanding at a time. i_mem_rsp_valid outside REFILL is ignored.
- Reset mid-operation returns to IDLE with all lines invalid. The memory side must be quiesced by the same reset; stray beats are ignored.
- Same-index conflict: a refill overwrites the line unconditionally (no dirty state).

Test Plan:
- Cold miss: reset, request 0x0000_1008 -> o_mem_req_addr=0x0000_1000; beats 0xA0,0xA1,0xA2,0xA3 -> o_rsp_valid in RESPOND with 0xA2.
- Hit: then request 0x0000_100C -> o_rsp_valid and o_hit exactly 1 cycle after acceptance, data 0xA3, no o_mem_req_valid.
- Conflict: request 0x0000_2008 (same index, tag 0x00002) -> miss, refill, and a following 0x0000_1008 misses again.
- Backpressure and gaps: hold i_mem_req_ready=0 for 5 cycles and insert 2 idle cycles between beats -> o_mem_req_valid and address stable throughout; correct word returned; exactly 4 beats consumed.
- Flush: pulse i_flush during REFILL -> response still delivered, o_req_ready=0 for the flush IDLE cycle, and a re-request of the same address misses.
- Reset mid-REFILL after 2 beats -> state IDLE, o_rsp_valid never asserts, and a subsequent request to that address misses.
